// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared system bus: one-hot grant held for a whole
// tenure, one dead turnaround cycle between owners, and a stall watchdog.
module bus_rr_arbiter #(
    parameter int N       = 6,
    parameter int ID_W    = 3,
    parameter int TIMEOUT = 64
) (
    input  logic            BUS_CLK,
    input  logic            RST,
    input  logic [N-1:0]    BR,
    input  logic [N-1:0]    ACK_OUT,
    output logic [N-1:0]    BG,
    output logic            ACK_IN,
    output logic            BUS_BUSY,
    output logic [ID_W-1:0] GRANT_ID,
    output logic            TIMEOUT_ERR,
    output logic [1:0]      state_dbg
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic            found;
    logic [ID_W-1:0] winner;
    logic            owner_ack;
    logic            owner_req;
    logic            timeout_hit;
    logic            tenure_end;
    logic [ID_W-1:0] next_ptr;

    assign ACK_IN    = |ACK_OUT;
    assign state_dbg = state;

    // BG is one-hot, so masking with it picks out the owner's own bits.
    assign owner_ack   = |(ACK_OUT & BG);
    assign owner_req   = |(BR & BG);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign tenure_end  = owner_ack || !owner_req || timeout_hit;
    assign next_ptr    = (GRANT_ID == LAST_ID) ? '0 : GRANT_ID + ID_W'(1);

    // Scan from ptr upward, wrapping modulo N; the first requester found wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && BR[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            BG          <= '0;
            BUS_BUSY    <= 1'b0;
            GRANT_ID    <= '0;
            TIMEOUT_ERR <= 1'b0;
            cnt         <= '0;
            ptr         <= '0;
        end else begin
            TIMEOUT_ERR <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (found) begin
                        BG       <= {{(N-1){1'b0}}, 1'b1} << winner;
                        GRANT_ID <= winner;
                        BUS_BUSY <= 1'b1;
                        cnt      <= '0;
                        state    <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (tenure_end) begin
                        BG          <= '0;
                        BUS_BUSY    <= 1'b0;
                        GRANT_ID    <= '0;
                        ptr         <= next_ptr;
                        state       <= RELEASE;
                        // Only a pure stall is an error; ACK or abandon wins the tie.
                        TIMEOUT_ERR <= !owner_ack && owner_req && timeout_hit;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    BG       <= '0;
                    BUS_BUSY <= 1'b0;
                    GRANT_ID <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: vector table plus hand-written
// sequences for reset, round-robin, abandon, watchdog and ACK/timeout tie.
module tb_bus_rr_arbiter;

    localparam int N       = 6;
    localparam int ID_W    = 3;
    localparam int TIMEOUT = 8;
    localparam int EXP_W   = 13;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_G = 2'd1;
    localparam logic [1:0] ST_R = 2'd2;

    logic            BUS_CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    BR;
    logic [N-1:0]    ACK_OUT;
    logic [N-1:0]    BG;
    logic            ACK_IN;
    logic            BUS_BUSY;
    logic [ID_W-1:0] GRANT_ID;
    logic            TIMEOUT_ERR;
    logic [1:0]      state_dbg;

    typedef struct {
        logic [N-1:0]     br;
        logic [N-1:0]     ack;
        logic [EXP_W-1:0] exp;
    } vec_t;

    logic [EXP_W-1:0] exp_q[$];
    vec_t             vecs[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               step_no = 0;

    bus_rr_arbiter #(.N(N), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .BUS_CLK    (BUS_CLK),
        .RST        (RST),
        .BR         (BR),
        .ACK_OUT    (ACK_OUT),
        .BG         (BG),
        .ACK_IN     (ACK_IN),
        .BUS_BUSY   (BUS_BUSY),
        .GRANT_ID   (GRANT_ID),
        .TIMEOUT_ERR(TIMEOUT_ERR),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial forever #5 BUS_CLK = ~BUS_CLK;

    // ---------------- expected-value helpers ----------------
    // Packed as {state, timeout_err, bus_busy, grant_id, bg}.
    function automatic logic [EXP_W-1:0] pk(input logic [1:0] st, input logic err,
                                            input logic busy, input logic [ID_W-1:0] id,
                                            input logic [N-1:0] bg);
        return {st, err, busy, id, bg};
    endfunction

    function automatic logic [EXP_W-1:0] eg(input int id);
        logic [N-1:0] one;
        one = N'(1);
        return pk(ST_G, 1'b0, 1'b1, ID_W'(id), one << id);
    endfunction

    function automatic logic [EXP_W-1:0] er(input logic err);
        return pk(ST_R, err, 1'b0, '0, '0);
    endfunction

    function automatic logic [EXP_W-1:0] ei();
        return pk(ST_I, 1'b0, 1'b0, '0, '0);
    endfunction

    function automatic logic [N-1:0] bit_of(input int id);
        logic [N-1:0] one;
        one = N'(1);
        return one << id;
    endfunction

    function automatic vec_t mkv(input logic [N-1:0] br, input logic [N-1:0] ack,
                                 input logic [EXP_W-1:0] e);
        vec_t v;
        v.br  = br;
        v.ack = ack;
        v.exp = e;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] observed();
        return {state_dbg, TIMEOUT_ERR, BUS_BUSY, GRANT_ID, BG};
    endfunction

    // Drive one cycle of inputs, then compare the registered outputs after the edge.
    task automatic step(input logic [N-1:0] br, input logic [N-1:0] ack,
                        input logic [EXP_W-1:0] e);
        logic [EXP_W-1:0] want;
        @(negedge BUS_CLK);
        BR      = br;
        ACK_OUT = ack;
        step_no++;
        #1;
        chk($sformatf("ack_in step %0d", step_no), 16'(ACK_IN), 16'(|ack));
        exp_q.push_back(e);
        @(posedge BUS_CLK);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("sb_empty step %0d", step_no), 16'(0), 16'(1));
        end else begin
            want = exp_q.pop_front();
            chk($sformatf("outputs{st,err,busy,id,bg} step %0d", step_no),
                16'(observed()), 16'(want));
        end
        chk($sformatf("bg_onehot0 step %0d", step_no), 16'($countones(BG) <= 1), 16'(1));
    endtask

    task automatic do_reset();
        @(negedge BUS_CLK);
        RST     = 1'b1;
        BR      = '0;
        ACK_OUT = '0;
        @(posedge BUS_CLK);
        #1;
        chk("reset_outputs", 16'(observed()), 16'(ei()));
        @(negedge BUS_CLK);
        RST = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int order[6];
        int hold;
        order = '{0, 1, 5, 0, 1, 5};

        RST     = 1'b1;
        BR      = '0;
        ACK_OUT = '0;
        repeat (2) @(posedge BUS_CLK);
        #1;
        chk("reset_state", 16'(observed()), 16'(ei()));
        @(negedge BUS_CLK);
        RST = 1'b0;

        // Single request to 2 with ACK in the 5th grant cycle, then one grant to 0.
        vecs.push_back(mkv(6'b000100, 6'b000000, eg(2)));
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(6'b000100, 6'b000000, eg(2)));
        vecs.push_back(mkv(6'b000100, 6'b000100, er(1'b0)));
        vecs.push_back(mkv(6'b000000, 6'b000000, ei()));
        vecs.push_back(mkv(6'b000001, 6'b000000, eg(0)));
        vecs.push_back(mkv(6'b000001, 6'b000001, er(1'b0)));
        vecs.push_back(mkv(6'b000000, 6'b000000, ei()));
        for (int i = 0; i < vecs.size(); i++) step(vecs[i].br, vecs[i].ack, vecs[i].exp);

        // Reset mid-tenure: pointer sits at 1 here, so only a real pointer reset
        // lets index 0 beat index 2 afterwards.
        step(6'b000001, 6'b000000, eg(0));
        step(6'b000001, 6'b000000, eg(0));
        #2;
        RST = 1'b1;
        BR  = '0;
        #1;
        chk("mid_tenure_reset", 16'(observed()), 16'(ei()));
        @(negedge BUS_CLK);
        RST = 1'b0;
        step(6'b000000, 6'b000000, ei());
        step(6'b000101, 6'b000000, eg(0));
        step(6'b000101, 6'b000001, er(1'b0));
        step(6'b000100, 6'b000000, eg(2));
        step(6'b000100, 6'b000100, er(1'b0));
        step(6'b000000, 6'b000000, ei());

        // Round-robin fairness with BR=100011 held, three grant cycles each.
        do_reset();
        step(6'b100011, 6'b000000, eg(order[0]));
        for (int k = 0; k < 6; k++) begin
            step(6'b100011, 6'b000000, eg(order[k]));
            step(6'b100011, 6'b000000, eg(order[k]));
            step(6'b100011, bit_of(order[k]), er(1'b0));
            if (k < 5) step(6'b100011, 6'b000000, eg(order[k + 1]));
        end
        step(6'b000000, 6'b000000, ei());

        // Foreign ACK is visible on ACK_IN but ignored; owner 2 then abandons.
        hold = $urandom_range(1, 4);
        step(6'b000100, 6'b000000, eg(2));
        step(6'b000100, 6'b010000, eg(2));
        repeat (hold) step(6'b000100, 6'b000000, eg(2));
        step(6'b000000, 6'b000000, er(1'b0));
        step(6'b000000, 6'b000000, ei());

        // Watchdog: owner 3 stalls for 8 grant cycles while 4 waits.
        step(6'b001000, 6'b000000, eg(3));
        repeat (7) step(6'b011000, 6'b000000, eg(3));
        step(6'b011000, 6'b000000, er(1'b1));
        step(6'b011000, 6'b000000, eg(4));
        step(6'b011000, 6'b010000, er(1'b0));
        step(6'b001000, 6'b000000, eg(3));
        step(6'b001000, 6'b001000, er(1'b0));
        step(6'b000000, 6'b000000, ei());

        // ACK lands in the same cycle the watchdog would fire: normal release.
        step(6'b000010, 6'b000000, eg(1));
        repeat (7) step(6'b000010, 6'b000000, eg(1));
        step(6'b000010, 6'b000010, er(1'b0));
        step(6'b000000, 6'b000000, ei());

        chk("sb_drained", 16'(exp_q.size()), 16'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench exceeded its time budget");
    end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter for the shared system bus (D/A/SIZE/RW) used by the cache, memory, DMA, keyboard and interrupt bus controllers.
- Takes one level-sensitive bus request per controller and issues a single one-hot grant.
- Holds each grant for a whole tenure and inserts one dead turnaround cycle between owners so the tristated D/A lines never overlap drivers.
- Adds a watchdog that revokes a grant when the owner stalls.

Parameters:
- N, 6, number of bus requesters (BR/BG/ACK_OUT width).
- ID_W, 3, width of encoded grant index; must satisfy 2^ID_W >= N.
- TIMEOUT, 64, maximum GRANT cycles without owner ACK before revocation; 0 disables the watchdog.

Ports:
- BUS_CLK  in  1  bus clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- BR  in  N  bus request, one bit per controller, level, held until the tenure ends.
- ACK_OUT  in  N  tenure-complete pulse from each controller.
- BG  out  N  bus grant, one-hot or zero, registered.
- ACK_IN  out  1  broadcast acknowledge: OR of all ACK_OUT bits, combinational.
- BUS_BUSY  out  1  high while in GRANT, registered.
- GRANT_ID  out  ID_W  encoded index of the current owner; 0 when BG==0.
- TIMEOUT_ERR  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async, RST=1): state=IDLE; BG=0; BUS_BUSY=0; GRANT_ID=0; TIMEOUT_ERR=0; watchdog counter=0; priority pointer=0, so index 0 has highest priority.
- Reset mid-tenure: BG drops in the same instant, with no RELEASE cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If BR!=0, select a winner by round-robin: scan from index ptr upward, wrapping modulo N; first set bit wins.
  - Next edge: BG=onehot(winner), GRANT_ID=winner, BUS_BUSY=1, counter=0, state=GRANT.
  - Grant latency is 1 cycle from BR sampled high.
- GRANT (owner o):
  - Counter increments each cycle, saturating at TIMEOUT.
  - End conditions, evaluated each edge in this priority order:
    - (a) ACK_OUT[o]=1: normal end.
    - (b) BR[o]=0: owner abandoned; normal end, no error.
    - (c) TIMEOUT!=0 and counter==TIMEOUT-1: revoke; TIMEOUT_ERR=1 for exactly the next cycle.
  - On any end: BG=0, BUS_BUSY=0, GRANT_ID=0, ptr=(o+1) mod N, state=RELEASE.
  - ACK_OUT bits from non-owners are ignored for state purposes; they still propagate to ACK_IN.
  - BR changes from other requesters never pre-empt the owner.
- RELEASE:
  - Lasts exactly one cycle with BG=0 (bus turnaround).
  - Arbitration is evaluated here with the updated ptr: if BR!=0, go to GRANT to the winner on the next edge; otherwise go to IDLE.
  - Back-to-back tenures are therefore separated by exactly one idle bus cycle.
- ACK and timeout in the same cycle: ACK wins, no TIMEOUT_ERR.
- A sole requester that re-asserts BR after release is re-granted after the RELEASE cycle; no starvation penalty applies.
- A revoked owner with BR still high is just another requester; it gets lowest priority because ptr has advanced past it.
- BG is never multi-hot; BG is never nonzero in IDLE or RELEASE.
- With N not a power of two, indices >= N are never granted.

Test Plan:
- Reset during GRANT: BR=6'b000001, grant to 0, assert RST mid-tenure -> BG=0 immediately; after release, state IDLE with ptr=0; BR=6'b000101 -> next grant goes to index 0.
- Single request: BR=6'b000100 at cycle 0 -> BG=6'b000100, GRANT_ID=2, BUS_BUSY=1 at cycle 1; ACK_OUT[2] pulse at cycle 5 -> BG=0 at cycle 6; IDLE at cycle 7.
- Round-robin fairness: BR=6'b100011 held; each owner ACKs after 3 cycles -> grant order 0,1,5,0,1,5; one BG=0 cycle between every pair of grants.
- Watchdog: TIMEOUT=8, BR[3]=1 with no ACK -> BG[3] high for exactly 8 cycles, then BG=0 and TIMEOUT_ERR=1 for one cycle; a pending BR[4] is granted after the RELEASE cycle.
- ACK on the timeout boundary: TIMEOUT=8, ACK_OUT[1] asserted in the 8th GRANT cycle -> normal release, TIMEOUT_ERR stays 0.
- Abandon and foreign ACK: owner 2 drops BR[2] without ACK -> release with no error; ACK_OUT[4]=1 while 2 owns -> ACK_IN=1 but BG[2] is held.
